seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Parametrised, bus-mapped multiplexed 7-segment display controller. It replaces the fixed 6-digit scan counter and rotating common driver in the SoC top. It sits on the data-memory bus beside GPIO, selected by the address decoder. It adds the following over the fixed scanner:
- configurable digit count
- hex or raw segment mode
- per-digit decimal point and blanking
- PWM brightness
- anti-ghosting dead cycle
- selectable output polarity

## Interface
Parameters:
- NUM_DIGITS, 6: number of digits / common lines, 1..16.
- SCAN_DIV, 32768: clock cycles per digit slot, ≥4.
- PWM_BITS, 4: brightness resolution.
- COM_ACTIVE_LOW, 0: 1 inverts every seg_com bit.
- SEG_ACTIVE_LOW, 0: 1 inverts every seg_data bit.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- cs, in, 1: chip select from the address decoder.
- wen, in, 1: write strobe, qualified by cs.
- ren, in, 1: read strobe, qualified by cs.
- addr, in, 8: byte offset. Bits [1:0] are ignored.
- wdata, in, 32: write data.
- rdata, out, 32: registered read data.
- seg_data, out, 8: segment outputs {a,b,c,d,e,f,g,dp}, MSB = a.
- seg_com, out, NUM_DIGITS: digit commons. At most one is active.

## Operation
Register map (word offsets):
- 0x00 CTRL, R/W.
  - [0] en, reset 1.
  - [1] raw, reset 0.
  - [PWM_BITS+7:8] bright, reset all ones.
- 0x04 STATUS, RO.
  - [3:0] current digit index.
  - [31:16] frame count: 16-bit wrapping counter of completed frames.
- 0x40+4·i DIGITi, R/W, [7:0], reset 0x00.
  - Hex mode: [3:0] nibble, [4] dp, [5] blank.
  - Raw mode: [7:0] is driven directly as {a..g,dp}.

Bus rules:
- Writes to unmapped offsets, STATUS, or DIGITi with i ≥ NUM_DIGITS are ignored.
- Reads of those unmapped offsets return 0.
- Writes use only the low bits of each field. Reads return the unused bits as 0.

Scan:
- psc counts 0..SCAN_DIV-1.
- At the terminal count, idx advances, wrapping NUM_DIGITS-1 → 0. On that wrap, frame count increments.
- pwm_cnt is a free-running PWM_BITS-bit counter.
- Digit idx is lit when all of the following hold: en, psc ≠ 0 (dead cycle), pwm_cnt ≤ bright, and, in hex mode, blank = 0.
- When idx is not lit, all commons are inactive and all segments are off.

Hex decode (active-high, dp excluded):
- 0:FC, 1:60, 2:DA, 3:F2, 4:66, 5:B6, 6:BE, 7:E0
- 8:FE, 9:F6, A:EE, b:3E, C:9C, d:7A, E:9E, F:8E
- dp ORs bit 0.

Polarity inversion is applied last, at the output register input.

en = 0:
- psc, idx and pwm_cnt are held at 0.
- Outputs go inactive.
- Re-enabling starts a fresh slot at digit 0. The frame count is held.

## Timing
- Reset:
  - psc = idx = pwm_cnt = frame count = 0.
  - seg_com = all inactive (all 1s if COM_ACTIVE_LOW).
  - seg_data = all off (0xFF if SEG_ACTIVE_LOW).
  - rdata = 0.
  - Registers take their listed reset values.
- Reset mid-frame aborts the scan immediately. The scan restarts at digit 0 on the first cycle after rst deasserts.
- seg_data and seg_com are registered. They reflect the state (psc, idx, pwm_cnt, DIGIT regs) of the previous cycle.
- Write at cycle t updates the register at t+1. A write to the currently lit digit is visible on seg_data at t+2. No tearing beyond this.
- Read: cs & ren at cycle t gives rdata valid at t+1. rdata holds its value until the next read.
- If cs & wen & ren are all set, the write takes effect and rdata returns the old value.
- Slot = SCAN_DIV cycles, of which 1 is dead. Frame = NUM_DIGITS·SCAN_DIV cycles.
- Duty within the lit window = (bright+1)/2^PWM_BITS.

## Structure
- Package seg_pkg holds:
  - register offsets (CTRL, STATUS, DIGIT_BASE)
  - field bit positions
  - the 16-entry hex segment table as a constant array
- Sub-module seg_hex_decode: combinational nibble+dp → 8-bit pattern.
- The top contains:
  - bus register file
  - psc/idx/frame counters
  - PWM counter
  - output register stage

## Test plan
- Reset with NUM_DIGITS=6, SCAN_DIV=4: seg_com=000000 and seg_data=00 during and after reset. With bright=15 and DIGITs=0, digit 0 lights with seg_data=FC; seg_com walks 000001→100000 every 4 cycles with 1 dead cycle per slot.
- Write DIGIT2=0x1A (nibble A, dp): seg_data=EF exactly while seg_com=000100. Write DIGIT3=0x20 (blank): com stays inactive for slot 3.
- Set CTRL raw=1 and DIGIT0=0x81: seg_data=81 in slot 0. Write to 0x58 (DIGIT6, out of range): read back returns 0, and no output changes.
- bright=3, PWM_BITS=4, SCAN_DIV=64: within each slot the lit cycles = 4 of every 16 pwm phases, excluding the dead cycle. Measured duty is within ±1 cycle.
- Clear en mid-slot 4: outputs inactive 1 cycle later, STATUS idx=0. Set en again: digit 0 is lit after the dead cycle. The frame count increments only on a full wrap.
- COM_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1: reset outputs 111111/FF. Digit 0 with value 8 gives seg_com=111110, seg_data=01.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared register map, field positions and the hex segment table for the
// multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int MAX_DIGITS = 16;

  // Byte offsets; only bits [7:2] take part in decoding.
  localparam logic [7:0] OFF_CTRL       = 8'h00;
  localparam logic [7:0] OFF_STATUS     = 8'h04;
  localparam logic [7:0] OFF_DIGIT_BASE = 8'h40;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_RAW_BIT     = 1;
  localparam int CTRL_BRIGHT_LSB  = 8;
  localparam int STATUS_IDX_LSB   = 0;
  localparam int STATUS_FRAME_LSB = 16;
  localparam int DIG_DP_BIT       = 4;
  localparam int DIG_BLANK_BIT    = 5;

  // Active-high {a,b,c,d,e,f,g,dp} patterns, dp cleared.
  localparam logic [7:0] HEX_SEG [MAX_DIGITS] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to 7-segment pattern, with the decimal point
// merged into bit 0.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i] | {7'b0, dp_i};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Bus-mapped multiplexed 7-segment scanner: register file, slot/digit/frame
// counters, PWM dimming and a registered, polarity-adjusted output stage.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 32768,
  parameter int PWM_BITS       = 4,
  parameter int COM_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [7:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [7:0]            seg_data,
  output logic [NUM_DIGITS-1:0] seg_com
);

  localparam int PSC_W = $clog2(SCAN_DIV);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
  localparam logic [3:0] IDX_LAST = 4'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] COM_OFF =
    (COM_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic                  en_q, raw_q;
  logic [PWM_BITS-1:0]   bright_q;
  logic [7:0]            digit_q [MAX_DIGITS];
  logic [PSC_W-1:0]      psc_q;
  logic [3:0]            idx_q;
  logic [PWM_BITS-1:0]   pwm_q;
  logic [15:0]           frame_q;
  logic [31:0]           rdata_q;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic [7:0]            seg_q, seg_d;

  logic        wr, rd, is_ctrl, is_status, is_digit, lit;
  logic [3:0]  dsel;
  logic [31:0] rd_val;
  logic [7:0]  cur, hex_seg;
  logic        unused_bits;

  assign wr        = cs & wen;
  assign rd        = cs & ren;
  assign dsel      = addr[5:2];
  assign is_ctrl   = (addr[7:2] == OFF_CTRL[7:2]);
  assign is_status = (addr[7:2] == OFF_STATUS[7:2]);
  assign is_digit  = (addr[7:6] == OFF_DIGIT_BASE[7:6]) && ({28'd0, dsel} < NUM_DIGITS);
  assign unused_bits = ^{addr[1:0], wdata};

  always_comb begin
    rd_val = '0;
    if (is_ctrl) begin
      rd_val[CTRL_EN_BIT]                   = en_q;
      rd_val[CTRL_RAW_BIT]                  = raw_q;
      rd_val[CTRL_BRIGHT_LSB +: PWM_BITS]   = bright_q;
    end else if (is_status) begin
      rd_val[STATUS_IDX_LSB +: 4]           = idx_q;
      rd_val[STATUS_FRAME_LSB +: 16]        = frame_q;
    end else if (is_digit) begin
      rd_val[7:0]                           = digit_q[dsel];
    end
  end

  // rdata captures the pre-write contents, so a combined read+write returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b1;
      raw_q    <= 1'b0;
      bright_q <= '1;
      rdata_q  <= '0;
      for (int i = 0; i < MAX_DIGITS; i++) digit_q[i] <= '0;
    end else begin
      if (wr && is_ctrl) begin
        en_q     <= wdata[CTRL_EN_BIT];
        raw_q    <= wdata[CTRL_RAW_BIT];
        bright_q <= wdata[CTRL_BRIGHT_LSB +: PWM_BITS];
      end
      if (wr && is_digit) digit_q[dsel] <= wdata[7:0];
      if (rd) rdata_q <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q   <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      frame_q <= '0;
    end else if (!en_q) begin
      psc_q <= '0;
      idx_q <= '0;
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
      if (psc_q == PSC_LAST) begin
        psc_q <= '0;
        if (idx_q == IDX_LAST) begin
          idx_q   <= '0;
          frame_q <= frame_q + 16'd1;
        end else begin
          idx_q <= idx_q + 4'd1;
        end
      end else begin
        psc_q <= psc_q + 1'b1;
      end
    end
  end

  assign cur = digit_q[idx_q];

  seg_hex_decode u_hex (
    .nibble_i (cur[3:0]),
    .dp_i     (cur[DIG_DP_BIT]),
    .seg_o    (hex_seg)
  );

  // psc == 0 is the anti-ghosting dead cycle between digit slots.
  always_comb begin
    lit   = en_q && (psc_q != '0) && (pwm_q <= bright_q) && (raw_q || !cur[DIG_BLANK_BIT]);
    com_d = (lit ? (NUM_DIGITS'(1) << idx_q) : '0) ^ COM_OFF;
    seg_d = (lit ? (raw_q ? cur : hex_seg) : 8'h00) ^ SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      com_q <= COM_OFF;
      seg_q <= SEG_OFF;
    end else begin
      com_q <= com_d;
      seg_q <= seg_d;
    end
  end

  assign rdata    = rdata_q;
  assign seg_com  = com_q;
  assign seg_data = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: an arithmetic scan model checked every
// cycle against an active-high and an inverted-polarity instance.
module tb_seg_scan_ctrl;

  localparam int N  = 6;
  localparam int SD = 4;
  localparam int PB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cs = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [7:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata0, rdata1;
  logic [7:0]   seg0, seg1;
  logic [N-1:0] com0, com1;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .PWM_BITS(PB),
                  .COM_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .cs(cs), .wen(wen), .ren(ren), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .seg_data(seg0), .seg_com(com0)
  );

  seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .PWM_BITS(PB),
                  .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u_dut_inv (
    .clk(clk), .rst(rst), .cs(cs), .wen(wen), .ren(ren), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .seg_data(seg1), .seg_com(com1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] hex_tab [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  bit           m_valid = 1'b0;
  bit           m_en, m_raw, m_lit;
  logic [3:0]   m_bright;
  logic [7:0]   m_dig [16];
  logic [7:0]   m_cur;
  int           m_t;          // cycles since the scan (re)started
  int           m_idx;
  logic [15:0]  m_frame;
  logic [N-1:0] exp_com;
  logic [7:0]   exp_seg;
  logic [31:0]  exp_rd;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int w;
    w = int'(a[7:2]);
    if (w == 0) return {20'b0, m_bright, 6'b0, m_raw, m_en};
    if (w == 1) return {m_frame, 12'b0, 4'((m_t / SD) % N)};
    if (w >= 16 && w < 16 + N) return {24'b0, m_dig[w-16]};
    return 32'h0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_en = 1'b1; m_raw = 1'b0; m_bright = 4'hF; m_t = 0; m_frame = '0;
      for (int i = 0; i < 16; i++) m_dig[i] = '0;
      exp_com = '0; exp_seg = '0; exp_rd = '0;
    end else begin
      m_idx = (m_t / SD) % N;
      m_cur = m_dig[m_idx];
      m_lit = m_en && (m_t % SD != 0) && ((m_t % 16) <= int'(m_bright)) &&
              (m_raw || !m_cur[5]);
      exp_com = m_lit ? N'(1 << m_idx) : '0;
      exp_seg = !m_lit ? 8'h00 : (m_raw ? m_cur : (hex_tab[m_cur[3:0]] | {7'b0, m_cur[4]}));
      if (cs && ren) exp_rd = model_read(addr);
      if (m_en) begin
        m_t++;
        if (m_t % (N * SD) == 0) m_frame++;
      end else begin
        m_t = 0;
      end
      if (cs && wen) begin
        if (addr[7:2] == 6'd0) begin
          m_en = wdata[0]; m_raw = wdata[1]; m_bright = wdata[11:8];
        end else if (int'(addr[7:2]) >= 16 && int'(addr[7:2]) < 16 + N) begin
          m_dig[int'(addr[7:2]) - 16] = wdata[7:0];
        end
      end
    end
    m_valid = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("com", {26'b0, com0}, {26'b0, exp_com});
      check("seg", {24'b0, seg0}, {24'b0, exp_seg});
      check("rdata", rdata0, exp_rd);
      check("com_inv", {26'b0, com1}, {26'b0, ~exp_com});
      check("seg_inv", {24'b0, seg1}, {24'b0, ~exp_seg});
      check("rdata_inv", rdata1, exp_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1'b1; wen = 1'b1; ren = 1'b0; addr = a; wdata = d;
    @(negedge clk); cs = 1'b0; wen = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); cs = 1'b1; ren = 1'b1; wen = 1'b0; addr = a;
    @(negedge clk); cs = 1'b0; ren = 1'b0;
    d = rdata0;
  endtask

  task automatic bus_rw(input logic [7:0] a, input logic [31:0] wd, output logic [31:0] d);
    @(negedge clk); cs = 1'b1; ren = 1'b1; wen = 1'b1; addr = a; wdata = wd;
    @(negedge clk); cs = 1'b0; ren = 1'b0; wen = 1'b0;
    d = rdata0;
  endtask

  task automatic wait_com(input logic [N-1:0] v, input int max, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (com0 == v) found = 1'b1;
    end
    check(name, {31'b0, found}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] d;
  int cnt;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_com", {26'b0, com0}, 32'h0);
    check("rst_seg", {24'b0, seg0}, 32'h0);
    check("rst_com_inv", {26'b0, com1}, 32'h3F);
    check("rst_seg_inv", {24'b0, seg1}, 32'hFF);
    check("rst_rdata", rdata0, 32'h0);
    rst = 1'b0;
    @(negedge clk); check("dead_after_rst", {26'b0, com0}, 32'h0);
    @(negedge clk); check("digit0_com", {26'b0, com0}, 32'h01);
    check("digit0_seg", {24'b0, seg0}, 32'hFC);
    wait_com(6'b100000, 30, "walk_to_digit5");

    bus_write(8'h48, 32'h1A);
    wait_com(6'b000100, 40, "find_digit2");
    check("dig2_hex_dp", {24'b0, seg0}, 32'hEF);

    bus_write(8'h4C, 32'h20);
    cnt = 0;
    repeat (30) begin @(negedge clk); if (com0 == 6'b001000) cnt++; end
    check("blank_slot3", cnt, 0);

    bus_read(8'h48, d); check("rd_dig2", d, 32'h1A);
    bus_read(8'h4C, d); check("rd_dig3", d, 32'h20);
    bus_write(8'h58, 32'hFF);
    bus_read(8'h58, d); check("rd_dig6_oor", d, 32'h0);
    bus_read(8'h08, d); check("rd_unmapped", d, 32'h0);
    bus_read(8'h00, d); check("rd_ctrl_reset", d, 32'h0F01);
    bus_write(8'h04, 32'hFFFF_FFFF);

    bus_write(8'h00, 32'h0F03);
    bus_write(8'h40, 32'h81);
    wait_com(6'b000001, 40, "find_raw_digit0");
    check("raw_seg", {24'b0, seg0}, 32'h81);

    bus_write(8'h00, 32'h0F01);
    bus_write(8'h4C, 32'h00);
    bus_write(8'h00, 32'h0301);
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (96) begin @(negedge clk); if (com0 != '0) cnt++; end
    check("pwm_duty_b3", cnt, 18);

    bus_rw(8'h44, 32'h05, d); check("rw_old_value", d, 32'h0);
    bus_read(8'h44, d); check("rw_new_value", d, 32'h05);

    bus_write(8'h00, 32'h0F01);
    wait_com(6'b010000, 40, "find_digit4");
    bus_write(8'h00, 32'h0F00);
    @(negedge clk);
    check("en_off_com", {26'b0, com0}, 32'h0);
    check("en_off_seg", {24'b0, seg0}, 32'h0);
    bus_read(8'h04, d); check("status_idx_off", d & 32'hF, 32'h0);
    repeat (5) @(negedge clk);

    bus_write(8'h00, 32'h0F01);
    check("reen_prev", {26'b0, com0}, 32'h0);
    @(negedge clk); check("reen_dead", {26'b0, com0}, 32'h0);
    @(negedge clk); check("reen_digit0", {26'b0, com0}, 32'h01);
    check("reen_seg", {24'b0, seg0}, 32'h60);
    repeat (50) @(negedge clk);
    bus_read(8'h04, d);

    bus_write(8'h40, 32'h08);
    wait_com(6'b000001, 40, "find_digit0_eight");
    check("inv_com", {26'b0, com1}, 32'h3E);
    check("inv_seg", {24'b0, seg1}, 32'h01);

    wait_com(6'b000100, 40, "find_digit2_pre_rst");
    rst = 1'b1;
    @(negedge clk); check("midrst_com", {26'b0, com0}, 32'h0);
    rst = 1'b0;
    @(negedge clk); check("midrst_dead", {26'b0, com0}, 32'h0);
    @(negedge clk); check("midrst_digit0", {26'b0, com0}, 32'h01);
    check("midrst_seg", {24'b0, seg0}, 32'hFC);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sequence did not complete");
    $fatal(1);
  end

endmodule
